fft_frame_sequencer: RTL
========================

# fft_frame_sequencer

Sequences the streaming FFT core: issues the per-frame config word, frames a free-running ADC sample stream into N-point input frames with a correct `tlast`, then tracks the result stream until the matching output frame completes. It sits between the ADC capture logic and the FFT core's config/data slave ports, and only monitors the result port, which the downstream consumer drives. Core error events are folded into a sticky error flag for software.

## Interface
Parameters:
- `DATA_W`, 12: ADC sample / FFT input width
- `LOG2_N`, 10: log2 of transform length (N = 1024)
- `CFG_W`, 8: config channel width
- `CFG_WORD`, 8'h01: config word sent each frame (bit0 = forward transform)

Ports:
- `aclk` in 1: single clock, all logic rising-edge
- `reset` in 1: asynchronous, active-high; clears all state and outputs
- `start` in 1: run one frame (sampled in IDLE only)
- `continuous` in 1: re-arm automatically after each frame
- `clear_err` in 1: clears `err` and `overrun`
- `adc_data` in DATA_W: sample
- `adc_valid` in 1: sample strobe; no backpressure possible
- `m_axis_config_tdata` out CFG_W, `m_axis_config_tvalid` out 1, `m_axis_config_tready` in 1
- `m_axis_data_tdata` out DATA_W, `m_axis_data_tvalid` out 1, `m_axis_data_tlast` out 1, `m_axis_data_tready` in 1
- `result_tvalid`, `result_tready`, `result_tlast` in 1 each: result-port monitor taps
- `event_tlast_missing`, `event_tlast_unexpected`, `event_data_in_channel_halt` in 1 each: core events
- `busy` out 1: state != IDLE
- `frame_done` out 1: one-cycle pulse on final result beat
- `frame_count` out 16: completed frames, wraps
- `err` out 1: sticky error
- `overrun` out 1: sticky, sample dropped during FILL

## Operation
- States: IDLE, CONFIG, FILL, DRAIN.
- IDLE: `start | continuous` → CONFIG.
- CONFIG: `m_axis_config_tvalid`=1, tdata=CFG_WORD, held until `tready`. On handshake → FILL.
- FILL: one-entry output register. `adc_valid` loads it when empty or draining the same cycle (`!tvalid | tready`). Otherwise the sample is dropped and `overrun` is set. `adc_valid` outside FILL is ignored. `in_cnt` (LOG2_N bits) increments per data handshake. `tlast`=1 while the registered beat is number N-1. On the handshake of beat N-1 → DRAIN. No further samples load.
- DRAIN: `out_cnt` increments per result handshake (`result_tvalid & result_tready`).
  - Handshake with `result_tlast` and out_cnt==N-1: pulse `frame_done`, `frame_count`+1, then → CONFIG if `continuous`, else IDLE.
  - `result_tlast` at out_cnt≠N-1, or out_cnt==N-1 without `result_tlast`: set `err`, then return as on completion (counters reset).
- Any core event input high in any state sets `err`. The state machine is not otherwise affected.
- `clear_err` clears the sticky flags. If an error source is asserted in the same cycle, the set wins.
- Counters clear on entry to CONFIG.

## Timing
- Reset values: state IDLE; all tvalid/tlast 0; tdata 0; `busy` 0; `frame_done` 0; `frame_count` 0; `err` 0; `overrun` 0. Reset mid-frame abandons the frame immediately. No recovery of the partial frame is attempted.
- `start` high at edge k in IDLE: `busy` and config tvalid are high from k+1.
- Config handshake at edge k: first ADC sample accepted at edge ≥ k+1.
- ADC sample accepted at edge k: appears on `m_axis_data_tdata` with tvalid from k+1 (latency 1).
- tvalid, once high, holds with stable tdata/tlast until tready (AXI-Stream rule).
- `frame_done` is high the cycle after the final result handshake. In continuous mode, config tvalid rises in that same cycle.
- With a constant `tready`=1 and an `adc_valid` strobe every cycle, a frame takes 1 + N cycles of input.

## Structure
- Shared package `fft_seq_pkg`: state enum `fft_seq_state_t`, `CFG_FWD` bit constant, default N/width constants.
- Sub-module `fft_seq_skid`: the one-entry output register with overrun detect. It is reusable for the config channel hold.
- Top: FSM, in/out counters, sticky flags.

## Test plan
- Single frame: `start` pulse, `adc_valid` every cycle with value 12'h7FF, tready=1, result model emits 1024 beats with tlast on beat 1023 → one config beat of 8'h01; exactly 1024 data beats; `tlast` only on beat 1023; `frame_done` once; `frame_count`=1; `err`=0.
- Backpressure: data tready toggles 50% while `adc_valid` runs every cycle → tdata stable across stalls, `overrun`=1, still exactly 1024 beats sent.
- Continuous: `continuous`=1 for 3 frames → `frame_count`=3, each frame preceded by one config beat, `busy` never drops.
- Early result tlast at beat 500 → `err`=1, FSM returns to IDLE. `clear_err` → `err`=0.
- `event_tlast_unexpected` pulsed mid-FILL → `err`=1, frame still completes normally.
- Reset asserted at data beat 300 → all outputs 0 within the same cycle. After release and `start`, a clean 1024-beat frame follows.

Source files
------------

// File: rtl/fft_seq_pkg.sv
// Shared types and defaults for the FFT frame sequencer.
package fft_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIG,
    S_FILL,
    S_DRAIN
  } fft_seq_state_t;

  // Bit position of the forward/inverse select in the FFT config word.
  localparam int CFG_FWD    = 0;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_LOG2_N = 10;
  localparam int DEF_CFG_W  = 8;

endpackage

// File: rtl/fft_seq_skid.sv
// One-entry output register: a beat loads when empty or draining that cycle, 1-cycle latency.
// in_rdy low means the register is held by a stalled consumer; the caller decides what a refused beat means.
module fft_seq_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  assign in_rdy  = !vld_q || out_rdy;
  assign out_vld = vld_q;
  assign out_dat = dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (in_vld && in_rdy) begin
      vld_d = 1'b1;
      dat_d = in_dat;
    end else if (out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Drives FFT config + N-point input frames from a free-running ADC and tracks the result frame.
// Data path latency 1 cycle; ADC cannot be stalled, so samples refused by a full register are dropped and flagged.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int                 DATA_W   = DEF_DATA_W,
  parameter int                 LOG2_N   = DEF_LOG2_N,
  parameter int                 CFG_W    = DEF_CFG_W,
  parameter logic [CFG_W-1:0]   CFG_WORD = CFG_W'(1 << CFG_FWD)
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              clear_err,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [CFG_W-1:0]  m_axis_config_tdata,
  output logic              m_axis_config_tvalid,
  input  logic              m_axis_config_tready,
  output logic [DATA_W-1:0] m_axis_data_tdata,
  output logic              m_axis_data_tvalid,
  output logic              m_axis_data_tlast,
  input  logic              m_axis_data_tready,
  input  logic              result_tvalid,
  input  logic              result_tready,
  input  logic              result_tlast,
  input  logic              event_tlast_missing,
  input  logic              event_tlast_unexpected,
  input  logic              event_data_in_channel_halt,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              err,
  output logic              overrun
);

  localparam logic [LOG2_N-1:0] LAST_IDX = '1;

  fft_seq_state_t    state_q, state_d;
  logic [LOG2_N-1:0] in_cnt_q, in_cnt_d;
  logic [LOG2_N-1:0] out_cnt_q, out_cnt_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
  logic              overrun_q, overrun_d;

  logic              cfg_load, cfg_in_rdy, cfg_vld;
  logic [CFG_W-1:0]  cfg_dat;
  logic              dat_in_vld, dat_in_rdy, dat_vld;
  logic [DATA_W:0]   dat_in, dat_out;
  logic [LOG2_N-1:0] ld_idx;
  logic              cfg_hs, dat_hs, res_hs, res_at_last, bad_end;

  fft_seq_skid #(.W(CFG_W)) u_cfg_reg (
    .clk     (aclk),
    .rst     (reset),
    .in_vld  (cfg_load && cfg_in_rdy),
    .in_dat  (CFG_WORD),
    .in_rdy  (cfg_in_rdy),
    .out_vld (cfg_vld),
    .out_dat (cfg_dat),
    .out_rdy (m_axis_config_tready)
  );

  // The data register carries tlast alongside the sample so both stay frozen during a stall.
  fft_seq_skid #(.W(DATA_W + 1)) u_dat_reg (
    .clk     (aclk),
    .rst     (reset),
    .in_vld  (dat_in_vld),
    .in_dat  (dat_in),
    .in_rdy  (dat_in_rdy),
    .out_vld (dat_vld),
    .out_dat (dat_out),
    .out_rdy (m_axis_data_tready)
  );

  always_comb begin
    state_d       = state_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    err_d         = err_q;
    overrun_d     = overrun_q;
    cfg_load      = 1'b0;
    bad_end       = 1'b0;

    cfg_hs      = cfg_vld && m_axis_config_tready;
    dat_hs      = dat_vld && m_axis_data_tready;
    res_hs      = result_tvalid && result_tready;
    res_at_last = (out_cnt_q == LAST_IDX);

    // A held beat means the next load lands one index further on (it can only load as that beat drains).
    ld_idx     = in_cnt_q + LOG2_N'(dat_vld);
    dat_in     = {ld_idx == LAST_IDX, adc_data};
    dat_in_vld = (state_q == S_FILL) && adc_valid && !(dat_vld && in_cnt_q == LAST_IDX);

    case (state_q)
      S_IDLE: begin
        if (start || continuous) begin
          state_d   = S_CONFIG;
          cfg_load  = 1'b1;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      S_CONFIG: begin
        if (cfg_hs) state_d = S_FILL;
      end
      S_FILL: begin
        if (dat_hs) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (dat_out[DATA_W]) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (res_hs) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (result_tlast || res_at_last) begin
            if (result_tlast && res_at_last) begin
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
            end else begin
              bad_end = 1'b1;
            end
            in_cnt_d  = '0;
            out_cnt_d = '0;
            if (continuous) begin
              state_d  = S_CONFIG;
              cfg_load = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Set beats clear when both happen in the same cycle.
    if (clear_err) begin
      err_d     = 1'b0;
      overrun_d = 1'b0;
    end
    if (bad_end || event_tlast_missing || event_tlast_unexpected || event_data_in_channel_halt)
      err_d = 1'b1;
    if (dat_in_vld && !dat_in_rdy)
      overrun_d = 1'b1;
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      frame_count_q <= '0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign m_axis_config_tdata  = cfg_dat;
  assign m_axis_config_tvalid = cfg_vld;
  assign m_axis_data_tdata    = dat_out[DATA_W-1:0];
  assign m_axis_data_tvalid   = dat_vld;
  assign m_axis_data_tlast    = dat_vld && dat_out[DATA_W];
  assign busy                 = (state_q != S_IDLE);
  assign frame_done           = frame_done_q;
  assign frame_count          = frame_count_q;
  assign err                  = err_q;
  assign overrun              = overrun_q;

endmodule
